cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 46 ++++
 rtl/cdb_arbiter_rr_pick.sv | 31 +++
 rtl/cdb_arbiter.sv | 78 +++++++
 tb/tb_cdb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Common data bus layout, functional-unit tags and requester indices
// shared by the CDB arbiter and its picker.
package cdb_arbiter_pkg;

   localparam int unsigned FU_W   = 3;
   localparam int unsigned RS_W   = 3;
   localparam int unsigned DATA_W = 32;

   localparam int unsigned NUM_CDBBITS   = 1 + FU_W + RS_W + DATA_W;
   localparam int unsigned PAYLOAD_W_DEF = NUM_CDBBITS - 1;
   localparam int unsigned NUM_REQ_DEF   = 5;
   localparam int unsigned CNT_W         = 16;

   // Bit positions of each field inside the full CDB word
   localparam int unsigned CDB_ON      = NUM_CDBBITS - 1;
   localparam int unsigned CDB_FU_HI   = CDB_ON - 1;
   localparam int unsigned CDB_FU_LO   = CDB_ON - FU_W;
   localparam int unsigned CDB_RS_HI   = CDB_FU_LO - 1;
   localparam int unsigned CDB_RS_LO   = CDB_FU_LO - RS_W;
   localparam int unsigned CDB_DATA_HI = DATA_W - 1;
   localparam int unsigned CDB_DATA_LO = 0;

   localparam logic [FU_W-1:0] FU_ALU = 3'd1;
   localparam logic [FU_W-1:0] FU_MEM = 3'd2;
   localparam logic [FU_W-1:0] FU_MUL = 3'd3;
   localparam logic [FU_W-1:0] FU_DIV = 3'd4;
   localparam logic [FU_W-1:0] FU_JMP = 3'd5;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_MEM = 1;
   localparam int unsigned REQ_MUL = 2;
   localparam int unsigned REQ_DIV = 3;
   localparam int unsigned REQ_JMP = 4;

   typedef struct packed {
      logic [FU_W-1:0]   fu;
      logic [RS_W-1:0]   rs;
      logic [DATA_W-1:0] data;
   } cdb_payload_t;

   typedef struct packed {
      logic         on;
      cdb_payload_t pl;
   } cdb_word_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of elig scanning upward from ptr
// with wrap-around.
module cdb_arbiter_rr_pick #(
   parameter int unsigned N     = 5,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     elig,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   int unsigned k;

   always_comb begin
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      k      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (32'(ptr) + i) % N;
         if (!any && elig[IDX_W'(k)]) begin
            any               = 1'b1;
            index             = IDX_W'(k);
            onehot[IDX_W'(k)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin owner of the common data bus; one unit per cycle, with the
// previous winner held off for a cycle so its request can drop.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
   parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] payload,
   input  logic                         flush,
   output logic [PAYLOAD_W:0]           cdb,
   output logic [NUM_REQ-1:0]           grant,
   output logic [CNT_W-1:0]             busy_cnt
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PAYLOAD_W:0]   cdb_d;
   logic [NUM_REQ-1:0]   grant_d, holdoff_q, holdoff_d, elig, pick_onehot;
   logic [IDX_W-1:0]     ptr_q, ptr_d, pick_idx;
   logic [CNT_W-1:0]     busy_d;
   logic                 pick_any;

   assign elig = req & ~holdoff_q;

   cdb_arbiter_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig   (elig),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .index  (pick_idx),
      .any    (pick_any)
   );

   // Next bus word; flush or no eligible unit idles the bus without moving ptr
   always_comb begin
      cdb_d     = '0;
      grant_d   = '0;
      holdoff_d = '0;
      ptr_d     = ptr_q;
      busy_d    = busy_q_sat();
      if (pick_any && !flush) begin
         cdb_d     = {1'b1, payload[32'(pick_idx)*PAYLOAD_W +: PAYLOAD_W]};
         grant_d   = pick_onehot;
         holdoff_d = pick_onehot;
         if (pick_idx == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
         else                                 ptr_d = pick_idx + IDX_W'(1);
      end else begin
         busy_d = busy_cnt;
      end
   end

   function automatic logic [CNT_W-1:0] busy_q_sat();
      return (busy_cnt == {CNT_W{1'b1}}) ? busy_cnt : busy_cnt + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb       <= '0;
         grant     <= '0;
         holdoff_q <= '0;
         ptr_q     <= '0;
         busy_cnt  <= '0;
      end else begin
         cdb       <= cdb_d;
         grant     <= grant_d;
         holdoff_q <= holdoff_d;
         ptr_q     <= ptr_d;
         busy_cnt  <= busy_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, alternation, rotation,
// flush recovery and busy counter saturation.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned NR = NUM_REQ_DEF;
   localparam int unsigned PW = PAYLOAD_W_DEF;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NR-1:0]        req = '0;
   logic [NR*PW-1:0]     payload = '0;
   logic                 flush = 1'b0;
   logic [PW:0]          cdb;
   logic [NR-1:0]        grant;
   logic [CNT_W-1:0]     busy_cnt;

   int checks = 0;
   int errors = 0;

   cdb_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .payload  (payload),
      .flush    (flush),
      .cdb      (cdb),
      .grant    (grant),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(input logic [FU_W-1:0] fu,
                                        input logic [RS_W-1:0] rs,
                                        input logic [DATA_W-1:0] data);
      cdb_payload_t p;
      p.fu = fu; p.rs = rs; p.data = data;
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; flush = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (cdb !== '0 || grant !== '0 || busy_cnt !== '0) begin
            errors++;
            $display("FAIL idle cyc%0d cdb=%h grant=%b busy=%0d want 0/0/0", c, cdb, grant, busy_cnt);
         end
      end
   endtask

   task automatic test_single();
      logic [PW-1:0] p;
      do_reset();
      p = mk(FU_ALU, 3'b100, 32'h0000_00AB);
      payload[REQ_ALU*PW +: PW] = p;
      req = 5'b00001;
      for (int c = 1; c <= 6; c++) begin
         step();
         checks++;
         if (c % 2 == 1) begin
            if (cdb !== {1'b1, p} || grant !== 5'b00001) begin
               errors++;
               $display("FAIL single cyc%0d cdb=%h grant=%b want %h/00001", c, cdb, grant, {1'b1, p});
            end
         end else if (cdb !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL single_hold cyc%0d cdb=%h grant=%b want 0/0", c, cdb, grant);
         end
      end
      checks++;
      if (busy_cnt !== 16'd3) begin
         errors++;
         $display("FAIL single_busy got %0d want 3", busy_cnt);
      end
      req = '0;
   endtask

   task automatic test_rotate();
      logic [NR-1:0] exp_g [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      int            exp_i [6] = '{0, 1, 2, 3, 4, 0};
      logic [PW-1:0] p [NR];
      do_reset();
      for (int i = 0; i < int'(NR); i++) begin
         p[i] = mk(3'(i + 1), 3'(1 << (i % 3)), 32'hC0DE_0000 + 32'(i));
         payload[i*PW +: PW] = p[i];
      end
      req = 5'b11111;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if (grant !== exp_g[c] || cdb !== {1'b1, p[exp_i[c]]}) begin
            errors++;
            $display("FAIL rotate cyc%0d grant=%b cdb=%h want %b/%h", c, grant, cdb, exp_g[c], {1'b1, p[exp_i[c]]});
         end
      end
      checks++;
      if (busy_cnt !== 16'd6) begin
         errors++;
         $display("FAIL rotate_busy got %0d want 6", busy_cnt);
      end
      req = '0;
   endtask

   task automatic test_two_and_async_reset();
      logic [NR-1:0] exp_g [3] = '{5'b00001, 5'b00100, 5'b00001};
      do_reset();
      payload[REQ_ALU*PW +: PW] = mk(FU_ALU, 3'b001, 32'h1111_1111);
      payload[REQ_MUL*PW +: PW] = mk(FU_MUL, 3'b010, 32'h3333_3333);
      req = 5'b00101;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (grant !== exp_g[c]) begin
            errors++;
            $display("FAIL two_req cyc%0d grant=%b want %b", c, grant, exp_g[c]);
         end
      end
      // Asynchronous reset while a word is on the bus
      #2 rst = 1'b1;
      #1;
      checks++;
      if (cdb[PW] !== 1'b0 || grant !== '0 || busy_cnt !== '0) begin
         errors++;
         $display("FAIL async_rst on=%b grant=%b busy=%0d want 0/0/0", cdb[PW], grant, busy_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++;
      if (grant !== 5'b00001) begin
         errors++;
         $display("FAIL rearb grant=%b want 00001", grant);
      end
      req = '0;
   endtask

   task automatic test_flush();
      logic [PW-1:0] pm;
      do_reset();
      pm = mk(FU_MUL, 3'b010, 32'hDEAD_BEEF);
      payload[REQ_ALU*PW +: PW] = mk(FU_ALU, 3'b001, 32'h0000_0001);
      payload[REQ_MUL*PW +: PW] = pm;
      req = 5'b00101;
      step();
      checks++;
      if (grant !== 5'b00001) begin
         errors++;
         $display("FAIL flush_pre grant=%b want 00001", grant);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (cdb !== '0 || grant !== '0) begin
         errors++;
         $display("FAIL flush_cyc cdb=%h grant=%b want 0/0", cdb, grant);
      end
      step();
      checks++;
      if (grant !== 5'b00100 || cdb !== {1'b1, pm}) begin
         errors++;
         $display("FAIL flush_post grant=%b cdb=%h want 00100/%h", grant, cdb, {1'b1, pm});
      end
      // Payload change after grant must not disturb the bus word
      payload[REQ_MUL*PW +: PW] = mk(FU_MUL, 3'b111, 32'h0BAD_0BAD);
      #1;
      checks++;
      if (cdb !== {1'b1, pm}) begin
         errors++;
         $display("FAIL payload_hold cdb=%h want %h", cdb, {1'b1, pm});
      end
      step();
      checks++;
      if (grant !== 5'b00001) begin
         errors++;
         $display("FAIL flush_ptr grant=%b want 00001", grant);
      end
      checks++;
      if (busy_cnt !== 16'd3) begin
         errors++;
         $display("FAIL flush_busy got %0d want 3", busy_cnt);
      end
      req = '0;
   endtask

   task automatic test_saturate();
      do_reset();
      req = 5'b11111;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy_cnt !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_pre got %h want FFFE", busy_cnt);
      end
      step();
      checks++;
      if (busy_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hit got %h want FFFF", busy_cnt);
      end
      repeat (5) step();
      checks++;
      if (busy_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold got %h want FFFF", busy_cnt);
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotate();
      test_two_and_async_reset();
      test_flush();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
